// File: rtl/pixel_fmt_pkg.sv
// Pixel format definitions shared by the framebuffer packer and the
// scan-out unpacker: layout encodings, colour byte lanes and the
// RGB888 -> RGB565 reduction.
package pixel_fmt_pkg;

  // Layout select. Only bit 1 carries meaning today; bit 0 is reserved.
  typedef enum logic [1:0] {
    BITCFG_RGB888 = 2'b00,
    BITCFG_RGB565 = 2'b10
  } bitcfg_e;

  // Bits of bitcfg that pick RGB565 over 24-bit packed.
  localparam logic [1:0] BITCFG_565_MASK = 2'b10;

  // Byte lane of each colour component within a 24-bit pixel.
  localparam int unsigned R_LANE = 2;
  localparam int unsigned G_LANE = 1;
  localparam int unsigned B_LANE = 0;

  // Truncating reduction to RGB565: {R[7:3], G[7:2], B[7:3]}.
  function automatic logic [15:0] rgb888_to_565(input logic [23:0] px);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = px[8*R_LANE +: 8];
    g = px[8*G_LANE +: 8];
    b = px[8*B_LANE +: 8];
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// Packs 24-bit RGB pixels into 32-bit framebuffer words, either as
// 24-bit packed (4 pixels per 3 words) or RGB565 (2 pixels per word).
// Bytes collect in an 8-byte buffer, oldest byte in lane 0; a word is
// offered whenever 4 bytes are present, or earlier to flush out a frame.
module pixel_packer
  import pixel_fmt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [1:0]  bitcfg_i,
  input  logic        pixel_valid_i,
  output logic        pixel_ready_o,
  input  logic [23:0] pixel_data_i,
  input  logic        pixel_last_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_data_o,
  output logic        word_last_o
);

  logic [63:0] buf_q, buf_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic        last_pend_q, last_pend_d;

  logic        emit;
  logic        accept;
  logic        mode_565;
  logic [3:0]  post_cnt;
  logic [63:0] post_buf;
  logic [23:0] in_bytes;
  logic [3:0]  in_nb;

  assign mode_565 = |(bitcfg_i & BITCFG_565_MASK);

  assign word_valid_o  = (byte_cnt_q >= 4'd4) | (last_pend_q & (byte_cnt_q != 4'd0));
  assign word_last_o   = last_pend_q & (byte_cnt_q <= 4'd4);
  assign word_data_o   = buf_q[31:0];
  assign emit          = word_valid_o & word_ready_i;
  // Room for 3 more bytes exists at count <= 4, or once this cycle's emit frees 4.
  assign pixel_ready_o = ~last_pend_q & ((byte_cnt_q <= 4'd4) | emit);
  assign accept        = pixel_valid_i & pixel_ready_o;

  // Stream bytes for one pixel, first byte in the low lane.
  always_comb begin
    in_bytes = 24'd0;
    in_nb    = 4'd3;
    if (mode_565) begin
      in_bytes = {8'd0, rgb888_to_565(pixel_data_i)};
      in_nb    = 4'd2;
    end else begin
      in_bytes = {pixel_data_i[8*B_LANE +: 8],
                  pixel_data_i[8*G_LANE +: 8],
                  pixel_data_i[8*R_LANE +: 8]};
    end
  end

  // Next state: drain a word on emit, then append the accepted pixel's bytes
  // just above whatever remains. Shifting in zeros keeps unused lanes at 0.
  always_comb begin
    post_cnt    = byte_cnt_q;
    post_buf    = buf_q;
    last_pend_d = last_pend_q;
    if (emit) begin
      post_buf = {32'd0, buf_q[63:32]};
      post_cnt = (byte_cnt_q >= 4'd4) ? (byte_cnt_q - 4'd4) : 4'd0;
      if (word_last_o) begin
        last_pend_d = 1'b0;
      end
    end
    buf_d      = post_buf;
    byte_cnt_d = post_cnt;
    if (accept) begin
      buf_d      = post_buf | ({40'd0, in_bytes} << {post_cnt, 3'b000});
      byte_cnt_d = post_cnt + in_nb;
      if (pixel_last_i) begin
        last_pend_d = 1'b1;
      end
    end
  end

  // State registers; flush aborts the frame exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      buf_q       <= 64'd0;
      byte_cnt_q  <= 4'd0;
      last_pend_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      byte_cnt_q  <= byte_cnt_d;
      last_pend_q <= last_pend_d;
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// Self-checking bench for pixel_packer: a byte-stream reference model
// pushes expected words into a queue; emitted words are popped and compared.
module tb_pixel_packer;
  import pixel_fmt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [1:0]  bitcfg_i;
  logic        pixel_valid_i;
  logic        pixel_ready_o;
  logic [23:0] pixel_data_i;
  logic        pixel_last_i;
  logic        word_valid_o;
  logic        word_ready_i;
  logic [31:0] word_data_o;
  logic        word_last_o;

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q[$];       // {last, data}
  logic [23:0] frame_px[$];
  logic        frame_last;

  pixel_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .bitcfg_i     (bitcfg_i),
    .pixel_valid_i(pixel_valid_i),
    .pixel_ready_o(pixel_ready_o),
    .pixel_data_i (pixel_data_i),
    .pixel_last_i (pixel_last_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .word_last_o  (word_last_o)
  );

  always #5 clk = ~clk;

  // Reference: serialise the frame to bytes, cut into words, zero-pad the tail.
  task automatic push_expected(input logic m565);
    logic [7:0]  bytes[$];
    logic [15:0] h;
    logic [31:0] w;
    int          nw;
    foreach (frame_px[i]) begin
      if (m565) begin
        h = {frame_px[i][23:19], frame_px[i][15:10], frame_px[i][7:3]};
        bytes.push_back(h[7:0]);
        bytes.push_back(h[15:8]);
      end else begin
        bytes.push_back(frame_px[i][23:16]);
        bytes.push_back(frame_px[i][15:8]);
        bytes.push_back(frame_px[i][7:0]);
      end
    end
    nw = (bytes.size() + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++) begin
        if (4*k + b < bytes.size()) w[8*b +: 8] = bytes[4*k + b];
      end
      exp_q.push_back({frame_last && (k == nw - 1), w});
    end
  endtask

  // One clock: drive at the falling edge, sample shortly after, let the rising edge pass.
  task automatic step(input logic pv, input logic [23:0] pd, input logic pl, input logic wr,
                      output logic acc, output logic emit, output logic vld,
                      output logic [32:0] obs);
    @(negedge clk);
    pixel_valid_i = pv;
    pixel_data_i  = pd;
    pixel_last_i  = pl;
    word_ready_i  = wr;
    #2;
    acc  = pv & pixel_ready_o;
    vld  = word_valid_o;
    emit = word_valid_o & wr;
    obs  = {word_last_o, word_data_o};
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pixel_valid_i = 1'b0;
    pixel_data_i  = 24'd0;
    pixel_last_i  = 1'b0;
    word_ready_i  = 1'b0;
  endtask

  // Stream frame_px through the DUT, popping the scoreboard on every emitted word.
  task automatic run_frame(input string name, input logic [1:0] cfg, input int ready_pct,
                           output int accept_cycles);
    int          idx;
    int          budget;
    logic        acc, emit, vld, wr;
    logic [32:0] obs, exp;
    bitcfg_i = cfg;
    push_expected(cfg[1]);
    idx = 0;
    accept_cycles = 0;
    budget = 40 * frame_px.size() + 40;
    while ((idx < frame_px.size() || exp_q.size() != 0) && budget > 0) begin
      wr = ($urandom_range(99) < ready_pct);
      if (idx < frame_px.size())
        step(1'b1, frame_px[idx], frame_last && (idx == frame_px.size() - 1), wr, acc, emit, vld, obs);
      else
        step(1'b0, 24'd0, 1'b0, wr, acc, emit, vld, obs);
      if (idx < frame_px.size()) accept_cycles++;
      if (acc) idx++;
      if (emit) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected word: got last=%0b data=%08h, none expected", name, obs[32], obs[31:0]);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            errors++;
            $display("FAIL %s word: got last=%0b data=%08h, expected last=%0b data=%08h",
                     name, obs[32], obs[31:0], exp[32], exp[31:0]);
          end else begin
            $display("  %s word last=%0b data=%08h ok", name, obs[32], obs[31:0]);
          end
        end
      end
      budget--;
    end
    idle_inputs();
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL %s timeout: %0d pixels sent of %0d, %0d words outstanding",
               name, idx, frame_px.size(), exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush_i = 1'b0;
    bitcfg_i = BITCFG_RGB888;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks += 4;
    if (word_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b expected 0", word_valid_o); end
    if (word_last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %0b expected 0", word_last_o); end
    if (word_data_o !== 32'd0) begin errors++; $display("FAIL reset_data got %08h expected 0", word_data_o); end
    if (pixel_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b expected 1", pixel_ready_o); end
    $display("  reset state checked");
  endtask

  task automatic test_pack24();
    int cyc;
    frame_px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    frame_last = 1'b0;
    // Fixed words from the layout definition guard the model itself.
    exp_q.push_back({1'b0, 32'h44332211});
    exp_q.push_back({1'b0, 32'h88776655});
    exp_q.push_back({1'b0, 32'hCCBBAA99});
    frame_px = '{};
    frame_px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    run_frame_fixed("pack24", cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL pack24_throughput got %0d cycles expected 4", cyc); end
  endtask

  // Same as run_frame but uses pre-loaded expectations, ready held high.
  task automatic run_frame_fixed(input string name, output int cyc);
    int          idx;
    int          budget;
    logic        acc, emit, vld;
    logic [32:0] obs, exp;
    bitcfg_i = BITCFG_RGB888;
    idx = 0;
    cyc = 0;
    budget = 50;
    while ((idx < frame_px.size() || exp_q.size() != 0) && budget > 0) begin
      if (idx < frame_px.size()) begin
        step(1'b1, frame_px[idx], 1'b0, 1'b1, acc, emit, vld, obs);
        cyc++;
      end else begin
        step(1'b0, 24'd0, 1'b0, 1'b1, acc, emit, vld, obs);
      end
      if (acc) idx++;
      if (emit) begin
        checks++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1DEADBEEF;
        if (obs !== exp) begin
          errors++;
          $display("FAIL %s word: got last=%0b data=%08h, expected last=%0b data=%08h",
                   name, obs[32], obs[31:0], exp[32], exp[31:0]);
        end else begin
          $display("  %s word data=%08h ok", name, obs[31:0]);
        end
      end
      budget--;
    end
    idle_inputs();
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL %s timeout: %0d words outstanding", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_rgb565();
    int cyc;
    frame_px = '{24'hFF0000, 24'h00FF00};
    frame_last = 1'b0;
    exp_q.push_back({1'b0, 32'h07E0F800});
    bitcfg_i = BITCFG_RGB565;
    // run_frame would push its own copy; drive manually against the fixed word.
    begin
      logic acc, emit, vld;
      logic [32:0] obs, exp;
      int idx = 0;
      int budget = 20;
      cyc = 0;
      while ((idx < 2 || exp_q.size() != 0) && budget > 0) begin
        if (idx < 2) begin
          step(1'b1, frame_px[idx], 1'b0, 1'b1, acc, emit, vld, obs);
          cyc++;
        end else begin
          step(1'b0, 24'd0, 1'b0, 1'b1, acc, emit, vld, obs);
        end
        if (acc) idx++;
        if (emit) begin
          checks++;
          exp = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1DEADBEEF;
          if (obs !== exp) begin
            errors++;
            $display("FAIL rgb565 word: got %09h expected %09h", obs, exp);
          end else begin
            $display("  rgb565 word data=%08h ok", obs[31:0]);
          end
        end
        budget--;
      end
      idle_inputs();
      checks++;
      if (budget == 0 || cyc != 2) begin
        errors++;
        $display("FAIL rgb565_throughput got %0d cycles (budget %0d) expected 2", cyc, budget);
      end
    end
  endtask

  task automatic test_last24();
    logic        acc, emit, vld;
    logic [32:0] obs;
    bitcfg_i = BITCFG_RGB888;
    step(1'b1, 24'h123456, 1'b1, 1'b0, acc, emit, vld, obs);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL last24_accept got %0b expected 1", acc); end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 24'hABCDEF, 1'b0, 1'b0, acc, emit, vld, obs);
      checks += 3;
      if (acc !== 1'b0) begin errors++; $display("FAIL last24_ready_low cycle %0d got accept=%0b expected 0", c, acc); end
      if (vld !== 1'b1) begin errors++; $display("FAIL last24_valid cycle %0d got %0b expected 1", c, vld); end
      if (obs !== {1'b1, 32'h00563412}) begin
        errors++; $display("FAIL last24_word cycle %0d got %09h expected 100563412", c, obs);
      end
    end
    step(1'b0, 24'd0, 1'b0, 1'b1, acc, emit, vld, obs);
    checks++;
    if (emit !== 1'b1 || obs !== {1'b1, 32'h00563412}) begin
      errors++; $display("FAIL last24_emit got emit=%0b word=%09h expected 1/100563412", emit, obs);
    end else begin
      $display("  last24 word data=%08h last=1 ok", obs[31:0]);
    end
    idle_inputs();
    @(negedge clk); #2;
    checks += 2;
    if (pixel_ready_o !== 1'b1) begin errors++; $display("FAIL last24_ready_after got %0b expected 1", pixel_ready_o); end
    if (word_valid_o !== 1'b0) begin errors++; $display("FAIL last24_valid_after got %0b expected 0", word_valid_o); end
  endtask

  task automatic test_backpressure();
    logic        acc, emit, vld;
    logic [32:0] obs, held, exp;
    int          idx = 0;
    int          unstable = 0;
    int          budget = 40;
    logic        have_held = 1'b0;
    bitcfg_i = BITCFG_RGB888;
    frame_px = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
    frame_last = 1'b0;
    push_expected(1'b0);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, frame_px[idx < 3 ? idx : 2], 1'b0, 1'b0, acc, emit, vld, obs);
      if (acc) idx++;
      if (vld) begin
        if (!have_held) begin held = obs; have_held = 1'b1; end
        else if (obs !== held) unstable++;
      end
    end
    checks += 3;
    if (idx !== 2) begin errors++; $display("FAIL bp_accepted got %0d expected 2", idx); end
    if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changes expected 0", unstable); end
    if (!have_held || held !== {1'b0, 32'h04030201}) begin
      errors++; $display("FAIL bp_held_word got %09h expected 004030201", held);
    end
    $display("  backpressure accepted=%0d held=%08h", idx, held[31:0]);
    while ((idx < 4 || exp_q.size() != 0) && budget > 0) begin
      if (idx < 4) step(1'b1, frame_px[idx], 1'b0, 1'b1, acc, emit, vld, obs);
      else         step(1'b0, 24'd0, 1'b0, 1'b1, acc, emit, vld, obs);
      if (acc) idx++;
      if (emit) begin
        checks++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1DEADBEEF;
        if (obs !== exp) begin
          errors++; $display("FAIL bp_word got %09h expected %09h", obs, exp);
        end else begin
          $display("  bp word data=%08h ok", obs[31:0]);
        end
      end
      budget--;
    end
    idle_inputs();
    checks++;
    if (budget == 0) begin errors++; $display("FAIL bp_timeout %0d words outstanding", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_flush();
    logic        acc, emit, vld;
    logic [32:0] obs;
    int          cyc;
    bitcfg_i = BITCFG_RGB888;
    step(1'b1, 24'h112233, 1'b0, 1'b1, acc, emit, vld, obs);
    step(1'b1, 24'h445566, 1'b0, 1'b1, acc, emit, vld, obs);
    step(1'b1, 24'h778899, 1'b0, 1'b1, acc, emit, vld, obs);
    checks++;
    if (!(acc && emit) || obs !== {1'b0, 32'h44332211}) begin
      errors++; $display("FAIL flush_pre_word got acc=%0b emit=%0b word=%09h expected 1/1/044332211", acc, emit, obs);
    end
    // Five bytes now buffered; flush while a handshake is also offered.
    @(negedge clk);
    flush_i = 1'b1;
    pixel_valid_i = 1'b1;
    pixel_data_i = 24'hFFFFFF;
    word_ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    idle_inputs();
    #2;
    checks += 3;
    if (word_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b expected 0", word_valid_o); end
    if (pixel_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b expected 1", pixel_ready_o); end
    if (word_data_o !== 32'd0) begin errors++; $display("FAIL flush_data got %08h expected 0", word_data_o); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (word_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_word got valid=%0b expected 0", word_valid_o); end
    $display("  flush discarded partial frame");
    frame_px = '{24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3, 24'hD1D2D3};
    frame_last = 1'b0;
    run_frame("flush_new", BITCFG_RGB888, 100, cyc);
  endtask

  task automatic test_565_last3();
    int cyc;
    frame_px = '{24'h123456, 24'h89ABCD, 24'hF0E0D0};
    frame_last = 1'b1;
    run_frame("rgb565_last3", BITCFG_RGB565, 100, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    frame_px = '{};
    for (int i = 0; i < 8; i++) frame_px.push_back(24'($urandom));
    frame_last = 1'b0;
    run_frame("b2b24", BITCFG_RGB888, 100, cyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL b2b24_throughput got %0d cycles expected 8", cyc); end
    for (int f = 0; f < 8; f++) begin
      frame_px = '{};
      for (int i = 0; i < 1 + $urandom_range(8); i++) frame_px.push_back(24'($urandom));
      frame_last = 1'b1;
      run_frame("random", ($urandom_range(1) != 0) ? BITCFG_RGB565 : BITCFG_RGB888, 60, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_pack24();
    test_rgb565();
    test_last24();
    test_backpressure();
    test_flush();
    test_565_last3();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
